// File: rtl/addr_conv_pkg.sv
// rtl/addr_conv_pkg.sv - shared mode encodings and S1->S2 control payload for addr_conv_pipe
//
// Contents:
//   conv_mode_e  : conversion direction carried with each transaction
//   conv_ctrl_t  : per-transaction control bits that travel from S1 to S2

package addr_conv_pkg;

    typedef enum logic {
        MODE_SM2TC = 1'b0,  // sign-magnitude -> two's complement, then add base
        MODE_TC2SM = 1'b1   // two's complement -> sign-magnitude
    } conv_mode_e;

    // flag meaning depends on mode:
    //   MODE_SM2TC : operand was a genuinely negative value (-0 excluded);
    //                S2 uses it to decide which carry state means wrap
    //   MODE_TC2SM : sign of the result
    typedef struct packed {
        conv_mode_e mode;
        logic       flag;
    } conv_ctrl_t;

endpackage

// File: rtl/addr_conv_core.sv
// rtl/addr_conv_core.sv - combinational negate/select used by the convert stage
//
// Ports:
//   mode_i  : conversion direction
//   sign_i  : sign-magnitude sign (MODE_SM2TC only)
//   addr_i  : magnitude (MODE_SM2TC) or two's-complement value (MODE_TC2SM)
//   conv_o  : two's-complement operand (MODE_SM2TC) or magnitude (MODE_TC2SM)
//   flag_o  : negative-operand flag (MODE_SM2TC) or result sign (MODE_TC2SM)

module addr_conv_core
    import addr_conv_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  conv_mode_e       mode_i,
    input  logic             sign_i,
    input  logic [WIDTH-1:0] addr_i,
    output logic [WIDTH-1:0] conv_o,
    output logic             flag_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic negate;

    always_comb begin
        negate = 1'b0;
        flag_o = 1'b0;
        if (mode_i == MODE_TC2SM) begin
            negate = addr_i[WIDTH-1];
            flag_o = addr_i[WIDTH-1];
        end else begin
            negate = sign_i;
            // -0 negates to 0 anyway; it must not count as negative for wrap detection
            flag_o = sign_i & (|addr_i);
        end
        // Most-negative input negates to itself, which read unsigned is 2^(WIDTH-1)
        conv_o = negate ? ((~addr_i) + ONE) : addr_i;
    end

endmodule

// File: rtl/addr_conv_pipe.sv
// rtl/addr_conv_pipe.sv - two-stage sign-magnitude/two's-complement address converter
//
// Optional feature: define ADDR_CONV_OVF_EN to add the out_ovf port and base-add wrap detection.
//
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : input handshake
//   in_addr, in_sign, in_mode    : operand, sign-magnitude sign, conversion direction
//   base_addr                    : base offset added in MODE_SM2TC
//   out_valid/out_ready          : output handshake
//   out_addr, out_sign           : converted result, result sign (MODE_TC2SM)
//   out_ovf                      : base-add wrap flag (ADDR_CONV_OVF_EN only)

module addr_conv_pipe
    import addr_conv_pkg::*;
#(
    parameter int WIDTH      = 9,
    parameter int RESET_BASE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_addr,
    input  logic             in_sign,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] base_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_addr,
    output logic             out_sign
`ifdef ADDR_CONV_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    // RESET_BASE is reserved and has no effect on the datapath
    logic unused_reset_base;
    assign unused_reset_base = ^RESET_BASE;

    // S1: convert stage
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_conv_q,  s1_conv_d;
    logic [WIDTH-1:0] s1_base_q,  s1_base_d;
    conv_ctrl_t       s1_ctrl_q,  s1_ctrl_d;

    // S2: base-add stage, drives the outputs directly
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_addr_q, out_addr_d;
    logic             out_sign_q, out_sign_d;
    logic             out_ovf_q,  out_ovf_d;

    logic             s1_ready;
    logic             s2_ready;
    logic [WIDTH-1:0] core_conv;
    logic             core_flag;
    logic [WIDTH:0]   sum;

    addr_conv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .mode_i (conv_mode_e'(in_mode)),
        .sign_i (in_sign),
        .addr_i (in_addr),
        .conv_o (core_conv),
        .flag_o (core_flag)
    );

    // A stage can take new data when empty or when its content leaves this cycle
    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;

    // Carry out of the unsigned add is the wrap indicator for a non-negative operand;
    // for a negative operand the true result is base - |v|, which goes below zero
    // exactly when there is no carry.
    assign sum = {1'b0, s1_conv_q} + {1'b0, s1_base_q};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_conv_d  = s1_conv_q;
        s1_base_d  = s1_base_q;
        s1_ctrl_d  = s1_ctrl_q;
        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_conv_d      = core_conv;
                s1_base_d      = base_addr;
                s1_ctrl_d.mode = conv_mode_e'(in_mode);
                s1_ctrl_d.flag = core_flag;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_addr_d = out_addr_q;
        out_sign_d = out_sign_q;
        out_ovf_d  = out_ovf_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_ctrl_q.mode == MODE_TC2SM) begin
                    out_addr_d = s1_conv_q;
                    out_sign_d = s1_ctrl_q.flag;
                    out_ovf_d  = 1'b0;
                end else begin
                    out_addr_d = sum[WIDTH-1:0];
                    out_sign_d = 1'b0;
                    out_ovf_d  = s1_ctrl_q.flag ^ sum[WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_conv_q  <= '0;
            s1_base_q  <= '0;
            s1_ctrl_q  <= '{mode: MODE_SM2TC, flag: 1'b0};
            s2_valid_q <= 1'b0;
            out_addr_q <= '0;
            out_sign_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_conv_q  <= s1_conv_d;
            s1_base_q  <= s1_base_d;
            s1_ctrl_q  <= s1_ctrl_d;
            s2_valid_q <= s2_valid_d;
            out_addr_q <= out_addr_d;
            out_sign_q <= out_sign_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_addr  = out_addr_q;
    assign out_sign  = out_sign_q;

`ifdef ADDR_CONV_OVF_EN
    assign out_ovf = out_ovf_q;
`else
    // Wrap goes unreported in this build
    logic unused_ovf;
    assign unused_ovf = out_ovf_q;
`endif

endmodule

// File: tb/tb_addr_conv_pipe.sv
// tb/tb_addr_conv_pipe.sv - directed self-checking bench for addr_conv_pipe (WIDTH=9)

module tb_addr_conv_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_addr;
    logic       in_sign;
    logic       in_mode;
    logic [8:0] base_addr;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_addr;
    logic       out_sign;
`ifdef ADDR_CONV_OVF_EN
    logic       out_ovf;
`endif

    int total = 0;
    int bad   = 0;

    addr_conv_pipe #(
        .WIDTH      (9),
        .RESET_BASE (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_sign   (in_sign),
        .in_mode   (in_mode),
        .base_addr (base_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_sign  (out_sign)
`ifdef ADDR_CONV_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One isolated transaction: accept, wait bounded for the result, check latency and value
    task automatic single(input string tag, input logic m, input logic s,
                          input logic [8:0] a, input logic [8:0] b,
                          input logic [8:0] ea, input logic es, input logic eo);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = m;
        in_sign   = s;
        in_addr   = a;
        base_addr = b;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        // Scramble sideband after the accept: only later transactions may see it
        in_valid  = 1'b0;
        in_mode   = ~m;
        in_sign   = ~s;
        in_addr   = ~a;
        base_addr = ~b;
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'd2);
        chk({tag, ".addr"}, 32'(out_addr), 32'(ea));
        chk({tag, ".sign"}, 32'(out_sign), 32'(es));
`ifdef ADDR_CONV_OVF_EN
        chk({tag, ".ovf"}, 32'(out_ovf), 32'(eo));
`else
        if (eo === 1'bx) chk({tag, ".ovf_arg"}, 32'(eo), 32'd0);
`endif
        tick();
        chk({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [8:0] exp_s [8];
        int tx, rx, c, last_c;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_sign   = 1'b0;
        in_mode   = 1'b0;
        base_addr = '0;
        out_ready = 1'b1;
        #1;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_addr", 32'(out_addr), 32'd0);
        chk("reset.out_sign", 32'(out_sign), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Sign-magnitude -> two's complement + base
        single("m0_neg5",      1'b0, 1'b1, 9'd5,   9'd0,   9'h1FB, 1'b0, 1'b1);
        single("m0_neg0",      1'b0, 1'b1, 9'd0,   9'd7,   9'd7,   1'b0, 1'b0);
        single("m0_wrap",      1'b0, 1'b0, 9'd300, 9'd300, 9'd88,  1'b0, 1'b1);
        single("m0_neg10_b20", 1'b0, 1'b1, 9'd10,  9'd20,  9'd10,  1'b0, 1'b0);
        single("m0_pos3_b4",   1'b0, 1'b0, 9'd3,   9'd4,   9'd7,   1'b0, 1'b0);
        // Two's complement -> sign-magnitude, base and in_sign ignored
        single("m1_mostneg",   1'b1, 1'b0, 9'h100, 9'd0,   9'd256, 1'b1, 1'b0);
        single("m1_minus1",    1'b1, 1'b0, 9'h1FF, 9'd0,   9'd1,   1'b1, 1'b0);
        single("m1_pos_base",  1'b1, 1'b0, 9'h0AB, 9'h055, 9'h0AB, 1'b0, 1'b0);
        single("m1_pos_sign",  1'b1, 1'b1, 9'd5,   9'd9,   9'd5,   1'b0, 1'b0);

        // Eight back-to-back transactions, downstream stalls in cycles 3..5
        for (int i = 0; i < 8; i++) exp_s[i] = 9'(i * 10 + 3);
        tx = 0;
        rx = 0;
        c = 0;
        last_c = -1;
        while (rx < 8 && c < 40) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (tx < 8);
            in_mode   = 1'b0;
            in_sign   = 1'b0;
            in_addr   = 9'(tx * 10 + 1);
            base_addr = 9'd2;
            #1;
            if (c == 2) chk("stream.in_ready_c2", 32'(in_ready), 32'd1);
            if (c >= 3 && c <= 5) begin
                chk("stream.stall_valid", 32'(out_valid), 32'd1);
                chk("stream.full_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_valid) begin
                chk("stream.addr", 32'(out_addr), 32'(exp_s[rx]));
                chk("stream.sign", 32'(out_sign), 32'd0);
            end
            if (out_valid && out_ready) begin
                last_c = c;
                rx++;
            end
            if (in_valid && in_ready) tx++;
            tick();
            c++;
        end
        chk("stream.received", 32'(rx), 32'd8);
        chk("stream.sent", 32'(tx), 32'd8);
        chk("stream.last_emit_cycle", 32'(last_c), 32'd12);
        in_valid = 1'b0;
        tick();

        // Reset with two transactions in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_sign   = 1'b0;
        in_addr   = 9'd1;
        base_addr = 9'd1;
        tick();
        in_addr = 9'd2;
        tick();
        in_valid = 1'b0;
        #1;
        chk("rst.pre_valid", 32'(out_valid), 32'd1);
        chk("rst.pre_full_in_ready", 32'(in_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("rst.async_out_valid", 32'(out_valid), 32'd0);
        chk("rst.async_out_addr", 32'(out_addr), 32'd0);
        chk("rst.async_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst.release_in_ready", 32'(in_ready), 32'd1);
        chk("rst.release_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("rst.no_stale", 32'(out_valid), 32'd0);
        single("rst.after", 1'b0, 1'b0, 9'd40, 9'd2, 9'd42, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
